// File: rtl/naive_bus_pkg.sv
// naive_bus_pkg: shared types and constants for naive_bus masters
package naive_bus_pkg;
    typedef enum logic [2:0] {IDLE, RD, RDATA, WR, DONE} dma_state_t;
    localparam logic [3:0]  BE_WORD    = 4'hF;
    localparam logic [31:0] WORD_BYTES = 32'd4;
endpackage

// File: rtl/naive_bus.sv
// naive_bus: read/write request-grant bus between one master and one slave
// master drives rd_req/rd_be/rd_addr and wr_req/wr_be/wr_addr/wr_data;
// slave returns rd_gnt, rd_data (one cycle after the read transfer) and wr_gnt
interface naive_bus;
    logic        rd_req;
    logic        rd_gnt;
    logic [3:0]  rd_be;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        wr_req;
    logic        wr_gnt;
    logic [3:0]  wr_be;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    modport master (output rd_req, rd_be, rd_addr, input rd_gnt, rd_data,
                    output wr_req, wr_be, wr_addr, wr_data, input wr_gnt);
    modport slave  (input rd_req, rd_be, rd_addr, output rd_gnt, rd_data,
                    input wr_req, wr_be, wr_addr, wr_data, output wr_gnt);
endinterface

// File: rtl/naive_bus_dma.sv
// naive_bus_dma: single-channel word copy engine on a naive_bus master port
// clk, rst_n      : clock, asynchronous active-low reset
// start           : one-cycle copy request, accepted only in IDLE
// src_addr/dst_addr/word_cnt/dst_fixed : copy job, latched on accepted start
// busy, done      : busy from the cycle after start until DONE exits; done pulses in DONE
// bus             : naive_bus master port carrying the reads and writes
module naive_bus_dma
    import naive_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [15:0] word_cnt,
    input  logic        dst_fixed,
    output logic        busy,
    output logic        done,
    naive_bus.master    bus
);
    dma_state_t  state;
    logic [31:0] src, dst, data;
    logic [15:0] cnt;
    logic        fixed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            src   <= '0;
            dst   <= '0;
            data  <= '0;
            cnt   <= '0;
            fixed <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    src   <= src_addr & ~32'h3;
                    dst   <= dst_addr & ~32'h3;
                    cnt   <= word_cnt;
                    fixed <= dst_fixed;
                    state <= (word_cnt == 16'd0) ? DONE : RD;
                end
                RD: if (bus.rd_gnt) begin
                    src   <= src + WORD_BYTES;
                    state <= RDATA;
                end
                RDATA: begin
                    data  <= bus.rd_data;
                    state <= WR;
                end
                WR: if (bus.wr_gnt) begin
                    cnt   <= cnt - 16'd1;
                    dst   <= fixed ? dst : dst + WORD_BYTES;
                    // compare against the pre-decrement count: 1 means this was the last word
                    state <= (cnt == 16'd1) ? DONE : RD;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // every output is a decode of registered state, so grants never reach outputs combinationally
    assign busy        = state != IDLE;
    assign done        = state == DONE;
    assign bus.rd_req  = state == RD;
    assign bus.rd_be   = (state == RD) ? BE_WORD : 4'h0;
    assign bus.rd_addr = (state == RD) ? src : 32'h0;
    assign bus.wr_req  = state == WR;
    assign bus.wr_be   = (state == WR) ? BE_WORD : 4'h0;
    assign bus.wr_addr = (state == WR) ? dst : 32'h0;
    assign bus.wr_data = (state == WR) ? data : 32'h0;
endmodule

// File: tb/tb_naive_bus_dma.sv
// tb_naive_bus_dma: directed self-checking bench for naive_bus_dma
module tb_naive_bus_dma;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] word_cnt = '0;
    logic        dst_fixed = 1'b0;
    logic        busy, done;

    naive_bus bus_if ();

    naive_bus_dma dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .word_cnt(word_cnt), .dst_fixed(dst_fixed),
        .busy(busy), .done(done), .bus(bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] rom [8] = '{32'h000062b3, 32'h000302b7, 32'h00a00313, 32'h0062a023,
                             32'h00128293, 32'hfe5ff06f, 32'h11112222, 32'h33334444};

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a[31:5] == 27'd0) ? rom[a[4:2]] : (a ^ 32'hDEAD0000);
    endfunction

    int rd_count = 0, wr_count = 0, rd_wait = 0, wr_wait = 0;
    int rd_base = 0, wr_base = 0, lr = 0, lw = 0;
    int rd_stall_idx = -1, rd_stall_n = 0, wr_stall_idx = -1, wr_stall_n = 0;
    int stab_err = 0, both_err = 0, req_cycles = 0;
    logic        rd_pend = 1'b0, wr_pend = 1'b0;
    logic [31:0] rd_hold = '0, wr_hold = '0;
    logic [31:0] rd_log [$];
    logic [31:0] wa_log [$];
    logic [31:0] wd_log [$];

    assign bus_if.rd_gnt = !((rd_count - rd_base) == rd_stall_idx && rd_wait < rd_stall_n);
    assign bus_if.wr_gnt = !((wr_count - wr_base) == wr_stall_idx && wr_wait < wr_stall_n);

    // slave model: memory reads with one-cycle data, write log, protocol monitors
    always @(posedge clk) begin
        if (bus_if.rd_req && bus_if.rd_gnt) begin
            bus_if.rd_data <= rom_word(bus_if.rd_addr);
            rd_log.push_back(bus_if.rd_addr);
            rd_count <= rd_count + 1;
            rd_wait  <= 0;
        end else begin
            bus_if.rd_data <= 32'hBAD0BAD0;
            if (bus_if.rd_req) rd_wait <= rd_wait + 1;
        end
        if (bus_if.wr_req && bus_if.wr_gnt) begin
            wa_log.push_back(bus_if.wr_addr);
            wd_log.push_back(bus_if.wr_data);
            wr_count <= wr_count + 1;
            wr_wait  <= 0;
        end else if (bus_if.wr_req) begin
            wr_wait <= wr_wait + 1;
        end
        stab_err <= stab_err
                  + int'(rd_pend && (!bus_if.rd_req || bus_if.rd_addr !== rd_hold))
                  + int'(wr_pend && (!bus_if.wr_req || bus_if.wr_addr !== wr_hold));
        rd_pend  <= bus_if.rd_req && !bus_if.rd_gnt;
        wr_pend  <= bus_if.wr_req && !bus_if.wr_gnt;
        rd_hold  <= bus_if.rd_addr;
        wr_hold  <= bus_if.wr_addr;
        both_err <= both_err + int'(bus_if.rd_req && bus_if.wr_req);
        req_cycles <= req_cycles + int'(bus_if.rd_req || bus_if.wr_req);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wchk(input int k, input logic [31:0] a, input logic [31:0] d);
        chk($sformatf("wr%0d_addr", k), wa_log[lw + k], a);
        chk($sformatf("wr%0d_data", k), wd_log[lw + k], d);
    endtask

    task automatic rchk(input int k, input logic [31:0] a);
        chk($sformatf("rd%0d_addr", k), rd_log[lr + k], a);
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_rd_req"}, 32'(bus_if.rd_req), 0);
        chk({tag, "_wr_req"}, 32'(bus_if.wr_req), 0);
        chk({tag, "_rd_be"}, 32'(bus_if.rd_be), 0);
        chk({tag, "_wr_be"}, 32'(bus_if.wr_be), 0);
        chk({tag, "_rd_addr"}, bus_if.rd_addr, 0);
        chk({tag, "_wr_addr"}, bus_if.wr_addr, 0);
        chk({tag, "_wr_data"}, bus_if.wr_data, 0);
    endtask

    task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n, input logic f);
        @(negedge clk);
        src_addr = s; dst_addr = d; word_cnt = n; dst_fixed = f; start = 1'b1;
        rd_base = rd_count; wr_base = wr_count; lr = rd_log.size(); lw = wa_log.size();
    endtask

    // returns done latency in cycles after the start cycle; restart_at injects a second start
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                            input logic f, input int restart_at, input string tag, output int dly);
        launch(s, d, n, f);
        dly = -1;
        for (int i = 1; i <= 200 && dly < 0; i++) begin
            @(negedge clk);
            start = (i == restart_at);
            if (i == restart_at) begin
                src_addr = 32'h100; dst_addr = 32'h20F00; word_cnt = 16'd7; dst_fixed = 1'b1;
            end
            if (i == 1) begin
                chk({tag, "_busy_t1"}, 32'(busy), 1);
                chk({tag, "_rdreq_t1"}, 32'(bus_if.rd_req), 32'(n != 0));
            end
            if (done) dly = i;
        end
        start = 1'b0;
        if (dly < 0) chk({tag, "_done_timeout"}, 0, 1);
        @(negedge clk);
        chk({tag, "_busy_after"}, 32'(busy), 0);
        chk({tag, "_done_after"}, 32'(done), 0);
    endtask

    initial begin
        int dly;
        int rq0;
        bit hit;
        repeat (3) @(negedge clk);
        outs_zero("reset");
        rst_n = 1'b1;

        run_copy(32'h0, 32'h20000, 16'd4, 1'b0, 0, "zw4", dly);
        chk("zw4_latency", dly, 13);
        chk("zw4_nwr", wa_log.size() - lw, 4);
        wchk(0, 32'h20000, 32'h000062b3);
        wchk(1, 32'h20004, 32'h000302b7);
        wchk(2, 32'h20008, 32'h00a00313);
        wchk(3, 32'h2000C, 32'h0062a023);

        rd_stall_idx = 1; rd_stall_n = 2; wr_stall_idx = 2; wr_stall_n = 1;
        run_copy(32'h10, 32'h20100, 16'd4, 1'b0, 0, "stall", dly);
        rd_stall_idx = -1; wr_stall_idx = -1;
        chk("stall_latency", dly, 16);
        chk("stall_nwr", wa_log.size() - lw, 4);
        wchk(0, 32'h20100, 32'h00128293);
        wchk(1, 32'h20104, 32'hfe5ff06f);
        wchk(2, 32'h20108, 32'h11112222);
        wchk(3, 32'h2010C, 32'h33334444);
        chk("stall_addr_stable", stab_err, 0);

        rq0 = req_cycles;
        run_copy(32'h40, 32'h20000, 16'd0, 1'b0, 0, "zero", dly);
        chk("zero_latency", dly, 1);
        chk("zero_no_req", req_cycles - rq0, 0);
        chk("zero_nwr", wa_log.size() - lw, 0);

        run_copy(32'h0, 32'h20200, 16'd3, 1'b0, 4, "restart", dly);
        chk("restart_latency", dly, 10);
        chk("restart_nrd", rd_log.size() - lr, 3);
        rchk(0, 32'h0); rchk(1, 32'h4); rchk(2, 32'h8);
        wchk(0, 32'h20200, 32'h000062b3);
        wchk(1, 32'h20204, 32'h000302b7);
        wchk(2, 32'h20208, 32'h00a00313);

        run_copy(32'h7, 32'h30002, 16'd3, 1'b1, 0, "fixed", dly);
        chk("fixed_latency", dly, 10);
        chk("fixed_nwr", wa_log.size() - lw, 3);
        wchk(0, 32'h30000, 32'h000302b7);
        wchk(1, 32'h30000, 32'h00a00313);
        wchk(2, 32'h30000, 32'h0062a023);

        run_copy(32'hFFFF_FFF8, 32'h20300, 16'd3, 1'b0, 0, "wrap", dly);
        chk("wrap_latency", dly, 10);
        rchk(0, 32'hFFFF_FFF8); rchk(1, 32'hFFFF_FFFC); rchk(2, 32'h0000_0000);
        wchk(0, 32'h20300, 32'h2152FFF8);
        wchk(1, 32'h20304, 32'h2152FFFC);
        wchk(2, 32'h20308, 32'h000062b3);

        launch(32'h0, 32'h20400, 16'd4, 1'b0);
        hit = 1'b0;
        for (int i = 1; i <= 50 && !hit; i++) begin
            @(negedge clk);
            start = 1'b0;
            hit = bus_if.wr_req && (wr_count - wr_base == 1);
        end
        chk("abort_reached_wr2", 32'(hit), 1);
        chk("abort_wr2_addr", bus_if.wr_addr, 32'h20404);
        #1 rst_n = 1'b0;
        #1 outs_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_nwr", wr_count - wr_base, 1);

        run_copy(32'h8, 32'h20500, 16'd2, 1'b0, 0, "post", dly);
        chk("post_latency", dly, 7);
        chk("post_nwr", wa_log.size() - lw, 2);
        wchk(0, 32'h20500, 32'h00a00313);
        wchk(1, 32'h20504, 32'h0062a023);

        chk("never_both_req", both_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/naive_bus_dma.md
# naive_bus_dma

Single-channel naive_bus master that copies a block of 32-bit words from a source region to a destination region, one word at a time, through the naive_bus read/write handshakes. It sits on a master port of the naive_bus arbiter beside the CPU core. Typical uses are preloading video RAM (0x0002_0000) from instruction ROM contents and feeding the UART TX window (0x0003_0000) without CPU stores. Control comes from a register-block wrapper or a hardwired start.

## Interface
- No parameters; word count width is fixed at 16 bits.
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to begin a copy; sampled only in IDLE
- src_addr  in  32  source byte address; bits [1:0] ignored
- dst_addr  in  32  destination byte address; bits [1:0] ignored
- word_cnt  in  16  number of words to copy; 0 is legal
- dst_fixed  in  1  1 = destination address held constant (FIFO/UART target), 0 = increments
- busy  out  1  high from the cycle after start is accepted until DONE exits
- done  out  1  one-cycle pulse in DONE state
- bus  naive_bus.master  the copy port, with these signals:
  - rd_req, rd_be[3:0], rd_addr[31:0] driven by this block
  - rd_gnt, rd_data[31:0] returned by the slave
  - wr_req, wr_be[3:0], wr_addr[31:0], wr_data[31:0] driven by this block
  - wr_gnt returned by the slave

## Operation
- The bus protocol is decided as follows:
  - A read transfer occurs in the cycle where rd_req & rd_gnt.
  - rd_data is valid exactly one cycle later.
  - A write transfer occurs in the cycle where wr_req & wr_gnt.
  - Request and address stay stable until granted.
- rd_be = wr_be = 4'hF whenever the matching request is high, otherwise 0.
- State machine: IDLE, RD, RDATA, WR, DONE.
- IDLE:
  - On start, latch src_addr, dst_addr and word_cnt into internal registers, with address bits [1:0] forced to 0.
  - If word_cnt == 0, go to DONE. Otherwise go to RD.
- RD:
  - Drive rd_req = 1 and rd_addr = src register.
  - On rd_gnt, add 4 to src and go to RDATA.
- RDATA:
  - Capture bus.rd_data into the 32-bit data buffer.
  - Unconditionally go to WR.
- WR:
  - Drive wr_req = 1, wr_addr = dst register and wr_data = data buffer.
  - On wr_gnt, decrement the remaining count and add 4 to dst unless dst_fixed.
  - Then go to DONE if the decremented count == 0, else go to RD.
- DONE: done = 1, then go to IDLE.
- Address arithmetic is 32-bit modulo: 0xFFFF_FFFC + 4 wraps to 0x0000_0000 with no flag.
- start while busy is ignored, and the latched parameters are unchanged.
- start in the same cycle DONE exits (state is DONE) is ignored. It is accepted only in IDLE.
- The block never asserts rd_req and wr_req in the same cycle.

## Timing
- Reset values: state IDLE; busy 0; done 0; all rd_* and wr_* outputs 0; internal registers 0.
- Reset mid-transfer aborts immediately. The slave must tolerate a dropped request.
- start in cycle T: busy = 1 from T+1.
- Grant latency:
  - With rd_gnt and wr_gnt tied high, each word costs 3 cycles (RD, RDATA, WR).
  - Each wait cycle on either grant adds one cycle.
- Copy of N ≥ 1 words with zero-wait slaves:
  - The first rd_req is at T+1.
  - done pulses at T+1+3N.
  - busy falls at T+2+3N.
- word_cnt = 0: done at T+1, busy high only during T+1, no bus requests.
- All outputs are registered-state decodes; there is no combinational path from rd_gnt or wr_gnt to any output.

## Structure
- Shared package naive_bus_pkg, holding:
  - the dma_state_t enum {IDLE, RD, RDATA, WR, DONE}
  - the constant BE_WORD = 4'hF
  - the constant WORD_BYTES = 4
- Single module with no sub-modules. The datapath is three address/count registers plus a 32-bit buffer, small enough to stay inline.

## Test plan
- Zero-wait 4-word copy, src 0x0 (ROM model holding 0x000062b3, 0x000302b7, …) to dst 0x20000:
  - RAM 0x20000..0x2000C equals ROM words 0..3.
  - done at T+13.
- rd_gnt withheld 2 cycles on the 2nd read and wr_gnt withheld 1 cycle on the 3rd write:
  - Data is correct.
  - done is delayed by exactly 3 cycles.
  - rd_addr/wr_addr are held stable while waiting.
- word_cnt = 0 → done at T+1, rd_req/wr_req never asserted.
- start pulsed again mid-transfer with different src → ignored; original copy completes unchanged.
- dst_fixed = 1, 3 words to 0x30000 → three writes, all to 0x30000, with data in source order.
- src 0xFFFF_FFF8, 3 words → reads at 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- rst_n asserted in WR of word 2 → all outputs 0 the same cycle; the next start runs a full clean copy.
